// File: rtl/req_arb_pkg.sv
// Shared constants and types for the request arbiter that feeds the 4-to-2 encoder.
// The request count and index width are fixed by that encoder.
package req_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

    // Rotating pointer: the source after the one just served gets top priority.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority select: first set bit of pending scanning ptr, ptr+1, ... mod NUM_REQ.
module rr_pick
    import req_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        any    = |pending;
        // Walk from lowest priority to highest so the highest-priority hit is written last.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (pending[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Round-robin arbiter capturing request pulses into a pending register and presenting one
// one-hot grant at a time, with a ready handshake and a grant-withdrawal timeout.
module req_onehot_arbiter
    import req_arb_pkg::*;
#(
    parameter int unsigned PTR_RESET   = 0,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               ready_in,
    output logic [NUM_REQ-1:0] onehot_out,
    output logic               valid_out,
    output logic [NUM_REQ-1:0] pending_out,
    output logic               timeout_pulse
);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] onehot_q;
    logic               valid_q;
    logic               timeout_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_grant;
    logic               accept;
    logic               cnt_last;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] pending_next;
    logic [IDX_W-1:0]   ptr_adv;
    logic [NUM_REQ-1:0] pick_pending;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    always_comb begin
        in_grant     = (state_q == StGrant);
        accept       = in_grant & ready_in;
        clr          = accept ? onehot_q : '0;
        // A request landing on the bit being cleared survives: set wins.
        pending_next = (pending_q & ~clr) | req_in;
        ptr_adv      = ptr_after(idx_q);
        cnt_last     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        // IDLE picks from the registered pending; an accept picks the follow-on grant from
        // the post-clear pending with the advanced pointer, so back-to-back has no bubble.
        pick_pending = in_grant ? pending_next : pending_q;
        pick_ptr     = in_grant ? ptr_adv : ptr_q;
    end

    rr_pick u_rr_pick (
        .pending (pick_pending),
        .ptr     (pick_ptr),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= IDX_W'(PTR_RESET);
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_next;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        onehot_q <= pick_onehot;
                        idx_q    <= pick_idx;
                        valid_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (ready_in) begin
                        ptr_q <= ptr_adv;
                        if (pick_any) begin
                            onehot_q <= pick_onehot;
                            idx_q    <= pick_idx;
                            cnt_q    <= '0;
                        end else begin
                            onehot_q <= '0;
                            valid_q  <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end else if (cnt_last) begin
                        // Withdraw the grant but keep the request pending for a later turn.
                        timeout_q <= 1'b1;
                        onehot_q  <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= ptr_adv;
                        state_q   <= StIdle;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign onehot_out    = onehot_q;
    assign valid_out     = valid_q;
    assign pending_out   = pending_q;
    assign timeout_pulse = timeout_q;

    a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(onehot_q));
    a_valid   : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|onehot_q));

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Directed and randomized checks of req_onehot_arbiter against a behavioural model.
module tb_req_onehot_arbiter;

    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic       ready_in;
    logic [3:0] onehot_out;
    logic       valid_out;
    logic [3:0] pending_out;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;

    // Model state: pending set, priority pointer, granted source (-1 = none), wait count.
    logic [3:0] m_pending;
    int         m_ptr;
    int         m_grant;
    int         m_wait;
    logic       m_to;

    always #5 clk = ~clk;

    req_onehot_arbiter #(
        .PTR_RESET   (0),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .ready_in      (ready_in),
        .onehot_out    (onehot_out),
        .valid_out     (valid_out),
        .pending_out   (pending_out),
        .timeout_pulse (timeout_pulse)
    );

    function automatic int rr_first(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pending = 4'b0;
        m_ptr     = 0;
        m_grant   = -1;
        m_wait    = 0;
        m_to      = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [3:0] req, input logic rdy);
        logic [3:0] granted_bit;
        m_to = 1'b0;
        if (m_grant < 0) begin
            m_grant   = rr_first(m_pending, m_ptr);
            m_wait    = 0;
            m_pending = m_pending | req;
        end else begin
            granted_bit = 4'(1 << m_grant);
            if (rdy) begin
                m_pending = (m_pending & ~granted_bit) | req;
                m_ptr     = (m_grant + 1) % 4;
                m_grant   = rr_first(m_pending, m_ptr);
                m_wait    = 0;
            end else if (m_wait == int'(TO) - 1) begin
                m_to      = 1'b1;
                m_ptr     = (m_grant + 1) % 4;
                m_grant   = -1;
                m_pending = m_pending | req;
            end else begin
                m_wait    = m_wait + 1;
                m_pending = m_pending | req;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_oh;
        exp_oh = (m_grant < 0) ? 4'b0 : 4'(1 << m_grant);
        check("m_onehot", onehot_out, exp_oh);
        check("m_valid", {3'b0, valid_out}, {3'b0, (m_grant >= 0)});
        check("m_pending", pending_out, m_pending);
        check("m_timeout", {3'b0, timeout_pulse}, {3'b0, m_to});
    endtask

    // Drive inputs at a falling edge, step over the rising edge, check at the next falling edge.
    task automatic cycle(input logic [3:0] req, input logic rdy);
        req_in   = req;
        ready_in = rdy;
        model_step(req, rdy);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst_n    = 1'b0;
        req_in   = 4'b0;
        ready_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;

        // Round-robin from PTR_RESET=0 with ready held high: no bubbles.
        cycle(4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 1'b1);
            check("rr_grant", onehot_out, 4'(4'b0001 << k));
        end
        cycle(4'b0000, 1'b1);
        check("rr_done", {3'b0, valid_out}, 4'b0);

        // Single request latency, then accept leaves the pointer at 3.
        cycle(4'b0100, 1'b0);
        check("single_pend", pending_out, 4'b0100);
        cycle(4'b0000, 1'b0);
        check("single_grant", onehot_out, 4'b0100);
        cycle(4'b0000, 1'b1);
        check("single_clear", onehot_out, 4'b0000);
        cycle(4'b1001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("ptr3_first", onehot_out, 4'b1000);
        cycle(4'b0000, 1'b1);
        check("ptr_wrap", onehot_out, 4'b0001);
        cycle(4'b0000, 1'b1);

        // Set-wins collision on bit 1 in its own accept cycle.
        cycle(4'b0111, 1'b0);
        cycle(4'b0000, 1'b0);
        check("setwin_grant", onehot_out, 4'b0010);
        cycle(4'b0010, 1'b1);
        check("setwin_pend", pending_out, 4'b0111);
        check("setwin_next", onehot_out, 4'b0100);
        cycle(4'b0000, 1'b1);
        check("setwin_rr", onehot_out, 4'b0001);
        cycle(4'b0000, 1'b1);
        check("setwin_regrant", onehot_out, 4'b0010);
        cycle(4'b0000, 1'b1);

        // Timeout on source 0 while source 2 waits.
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        check("to_grant", onehot_out, 4'b0001);
        for (int i = 1; i <= int'(TO); i++) begin
            cycle((i == 3) ? 4'b0100 : 4'b0000, 1'b0);
            if (i < int'(TO)) check("to_hold", {3'b0, valid_out}, 4'b0001);
        end
        check("to_pulse", {3'b0, timeout_pulse}, 4'b0001);
        check("to_drop", {3'b0, valid_out}, 4'b0000);
        check("to_pend", pending_out, 4'b0101);
        cycle(4'b0000, 1'b0);
        check("to_pulse_end", {3'b0, timeout_pulse}, 4'b0000);
        check("to_other", onehot_out, 4'b0100);
        cycle(4'b0000, 1'b1);
        check("to_regrant", onehot_out, 4'b0001);
        cycle(4'b0000, 1'b1);

        // ready_in in the last allowed cycle is an accept, not a timeout.
        cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b0);
        for (int i = 1; i < int'(TO); i++) cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        check("edge_no_to", {3'b0, timeout_pulse}, 4'b0000);
        check("edge_clear", pending_out, 4'b0000);

        // Asynchronous reset in the middle of a grant.
        cycle(4'b0110, 1'b0);
        cycle(4'b0000, 1'b0);
        check("ar_grant", onehot_out, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("ar_onehot", onehot_out, 4'b0000);
        check("ar_valid", {3'b0, valid_out}, 4'b0000);
        check("ar_pend", pending_out, 4'b0000);
        check("ar_to", {3'b0, timeout_pulse}, 4'b0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b0000, 1'b0);
        check("ar_idle", pending_out, 4'b0000);

        // Randomized traffic; alternate bursts of eager and reluctant downstream.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] r;
            logic       rdy;
            r   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rdy = ((n / 100) % 2 == 1) ? ($urandom_range(0, 19) == 0)
                                       : ($urandom_range(0, 1) == 1);
            cycle(r, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
